seg7_scan_ctrl: RTL and testbench

Time-multiplexing scheduler that shares one 7-segment bus between NUM_DIGITS digits. It holds a small per-digit register file written through a simple write port. It cycles a one-hot active-low anode select at a prescaled rate and inserts a blanking cycle between digits to prevent ghosting. It sits between the board-level FSM logic, which writes digit values, and the physical segment/anode pins.

---
 rtl/seg7_scan_ctrl_if.sv | 33 +++
 rtl/seg7_scan_ctrl.sv | 179 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// Digit write port, scan enable and multiplexed display pins of seg7_scan_ctrl.
// blink_mask exists only when SEG7_BLINK_EN is defined.
interface seg7_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                  enable;
    logic                  wr_en;
    logic [2:0]            wr_addr;
    logic [3:0]            wr_data;
    logic                  wr_blank;
`ifdef SEG7_BLINK_EN
    logic [NUM_DIGITS-1:0] blink_mask;
`endif
    logic [6:0]            seg_n;
    logic [NUM_DIGITS-1:0] an_n;
    logic                  frame_done;

    modport master (
`ifdef SEG7_BLINK_EN
        output blink_mask,
`endif
        output enable, wr_en, wr_addr, wr_data, wr_blank,
        input  seg_n, an_n, frame_done
    );

    modport slave (
`ifdef SEG7_BLINK_EN
        input  blink_mask,
`endif
        input  enable, wr_en, wr_addr, wr_data, wr_blank,
        output seg_n, an_n, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with per-digit register file and
// a one-cycle blanking gap between digits. Optional blinking via SEG7_BLINK_EN.
module seg7_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 25000
`ifdef SEG7_BLINK_EN
    ,
    parameter int unsigned BLINK_FRAMES = 64
`endif
) (
    input logic           clk,
    input logic           reset,
    seg7_scan_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam logic [6:0]  SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                state, state_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic [IDX_W-1:0]      idx, idx_nx;
    logic                  frame_nx;
    logic                  tick_c;
    logic                  last_c;
    logic                  blink_off_c;

    logic [3:0]            digit_val [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] digit_blank;
    logic [IDX_W-1:0]      wr_idx;

    logic [6:0]            seg_q, seg_nx;
    logic [NUM_DIGITS-1:0] an_q, an_nx;
    logic                  frame_q;

    function automatic logic [6:0] seg7_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Digit register file; out-of-range addresses are dropped.
    assign wr_idx = bus.wr_addr[IDX_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_val[i] <= 4'h0;
            end
            digit_blank <= '1;
        end else if (bus.wr_en && (32'(bus.wr_addr) < NUM_DIGITS)) begin
            digit_val[wr_idx]   <= bus.wr_data;
            digit_blank[wr_idx] <= bus.wr_blank;
        end
    end

    // Next scan position; the blanking cycle consumes count 0 of each slot.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        frame_nx = 1'b0;
        tick_c   = (cnt == CNT_W'(SCAN_DIV - 1));
        last_c   = (idx == IDX_W'(NUM_DIGITS - 1));
        if (!bus.enable) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            idx_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
                BLANK: begin
                    state_nx = SHOW;
                    cnt_nx   = cnt + 1'b1;
                end
                SHOW: begin
                    if (tick_c) begin
                        state_nx = BLANK;
                        cnt_nx   = '0;
                        idx_nx   = last_c ? '0 : idx + 1'b1;
                        frame_nx = last_c;
                    end else begin
                        cnt_nx   = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
            endcase
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int unsigned FRM_W = $clog2(BLINK_FRAMES + 1);

    logic [FRM_W-1:0] frame_cnt;
    logic             blink_phase;

    // Blink phase flips after every BLINK_FRAMES completed frames.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!bus.enable) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_nx) begin
            if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt   <= frame_cnt + 1'b1;
            end
        end
    end

    assign blink_off_c = blink_phase & bus.blink_mask[idx_nx];
`else
    assign blink_off_c = 1'b0;
`endif

    // Pin values for the upcoming state, from the pre-write register file.
    always_comb begin
        seg_nx = SEG_OFF;
        an_nx  = '1;
        if (state_nx == SHOW) begin
            an_nx = ~(NUM_DIGITS'(1) << idx_nx);
            if (!digit_blank[idx_nx] && !blink_off_c) begin
                seg_nx = seg7_decode(digit_val[idx_nx]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            seg_q   <= SEG_OFF;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            seg_q   <= seg_nx;
            an_q    <= an_nx;
            frame_q <= frame_nx;
        end
    end

    assign bus.seg_n      = seg_q;
    assign bus.an_n       = an_q;
    assign bus.frame_done = frame_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed steps plus random traffic against a
// cycle-position reference model (blink checks when SEG7_BLINK_EN is defined).
module tb_seg7_scan_ctrl;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int BF = 2;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS(N),
        .SCAN_DIV(D)
`ifdef SEG7_BLINK_EN
        ,
        .BLINK_FRAMES(BF)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    logic [6:0]  seg_tab [16];
    int          k;
    logic [3:0]  mval [N];
    logic        mblank [N];
    logic [6:0]  exp_seg;
    logic [N-1:0] exp_an;
    logic        exp_fd;
    bit          found;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        k = 0;
        for (int i = 0; i < N; i++) begin
            mval[i]   = 4'h0;
            mblank[i] = 1'b1;
        end
    endtask

    // Expected pins from the number of enabled edges k since scanning began.
    task automatic model_expect();
        int          pos;
        int          slot;
        logic [IW-1:0] s;
        logic        off;
        exp_seg = 7'h7F;
        exp_an  = '1;
        exp_fd  = 1'b0;
        if (k > 0) begin
            pos    = (k - 1) % D;
            slot   = ((k - 1) / D) % N;
            s      = IW'(slot);
            exp_fd = (k > 1) && (((k - 1) % (N * D)) == 0);
            if (pos != 0) begin
                exp_an = ~(N'(1) << s);
                off    = mblank[s];
`ifdef SEG7_BLINK_EN
                if (((((k - 1) / (N * D)) / BF) % 2) == 1 && bus.blink_mask[s]) off = 1'b1;
`endif
                if (!off) exp_seg = seg_tab[mval[s]];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) begin
            model_clear();
            model_expect();
        end else begin
            if (!bus.enable) k = 0;
            else k++;
            model_expect();
            if (bus.wr_en && (bus.wr_addr < N)) begin
                mval[bus.wr_addr[IW-1:0]]   = bus.wr_data;
                mblank[bus.wr_addr[IW-1:0]] = bus.wr_blank;
            end
        end
        #1;
        chk("seg_n", 32'(bus.seg_n), 32'(exp_seg));
        chk("an_n", 32'(bus.an_n), 32'(exp_an));
        chk("frame_done", 32'(bus.frame_done), 32'(exp_fd));
    endtask

    // Advance until digit `want` has just entered its SHOW phase.
    task automatic seek_show(input int want, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < 3 * N * D; i++) begin
            if (k > 0 && ((k - 1) % D) == 1 && (((k - 1) / D) % N) == want) begin
                hit = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        bus.enable   = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = 3'd0;
        bus.wr_data  = 4'h0;
        bus.wr_blank = 1'b0;
`ifdef SEG7_BLINK_EN
        bus.blink_mask = '0;
`endif
        model_clear();

        // Reset state, then blank scanning with frame_done cadence
        repeat (2) step();
        reset = 1'b1;
        step();
        bus.enable = 1'b1;
        repeat (2 * N * D + 4) step();

        // Load 1,2,3,4 while idle, then scan them
        bus.enable = 1'b0;
        step();
        for (int i = 0; i < N; i++) begin
            bus.wr_en    = 1'b1;
            bus.wr_addr  = 3'(i);
            bus.wr_data  = 4'(i + 1);
            bus.wr_blank = 1'b0;
            step();
        end
        bus.wr_en  = 1'b0;
        bus.enable = 1'b1;
        repeat (2 * N * D) step();

        // Rewrite digit 2 while it is on display
        seek_show(2, found);
        chk("seek_show_d2", 32'(found), 32'd1);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd2;
        bus.wr_data = 4'hA;
        step();
        bus.wr_en = 1'b0;
        repeat (N * D) step();

        // Out-of-range address must be ignored
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 3'd5;
        bus.wr_data  = 4'h7;
        bus.wr_blank = 1'b1;
        step();
        bus.wr_en = 1'b0;
        repeat (N * D) step();

        // Mid-frame disable at digit 2, then restart
        seek_show(2, found);
        chk("seek_show_drop", 32'(found), 32'd1);
        bus.enable = 1'b0;
        repeat (3) step();
        bus.enable = 1'b1;
        repeat (N * D + 2) step();

`ifdef SEG7_BLINK_EN
        bus.enable = 1'b0;
        step();
        bus.blink_mask = N'(1);
        bus.enable = 1'b1;
        repeat (9 * N * D) step();
        bus.blink_mask = '0;
`endif

        // Asynchronous reset in the middle of a SHOW slot
        seek_show(1, found);
        chk("seek_show_rst", 32'(found), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_seg_n", 32'(bus.seg_n), 32'h7F);
        chk("async_an_n", 32'(bus.an_n), 32'(N'('1)));
        chk("async_frame_done", 32'(bus.frame_done), 32'd0);
        model_clear();
        step();
        reset = 1'b1;
        repeat (2 * N * D) step();

        // Random traffic
        repeat (800) begin
            bus.enable   = ($urandom_range(0, 63) != 0);
            bus.wr_en    = ($urandom_range(0, 3) == 0);
            bus.wr_addr  = 3'($urandom_range(0, 7));
            bus.wr_data  = 4'($urandom);
            bus.wr_blank = ($urandom_range(0, 3) == 0);
`ifdef SEG7_BLINK_EN
            bus.blink_mask = N'($urandom);
`endif
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
